// File: rtl/multi_counter_sram_pkg.sv
// multi_counter_sram_pkg: op encodings, pipeline micro-op and op decode helpers
package multi_counter_sram_pkg;
  typedef enum logic [2:0] {
    OP_NOP     = 3'b000,
    OP_QRY     = 3'b001,
    OP_RSV2    = 3'b010,
    OP_RSV3    = 3'b011,
    OP_INIT    = 3'b100,
    OP_ADD     = 3'b101,
    OP_SUB     = 3'b110,
    OP_QRY_CLR = 3'b111
  } op_t;
  localparam int OP_WRITE_B = 2;
  localparam int UC_ID_W = 16;
  localparam int UC_DAT_W = 64;
  typedef struct packed {
    op_t                 op;
    logic [UC_ID_W-1:0]  id;
    logic [UC_DAT_W-1:0] dat;
  } ucode_t;
  function automatic logic op_is_out(input op_t op);
    return op == OP_QRY || op == OP_QRY_CLR;
  endfunction
  function automatic logic op_is_wr(input op_t op);
    return op[OP_WRITE_B];
  endfunction
endpackage

// File: rtl/multi_counter_sram_if.sv
// multi_counter_sram_if: command, response and event bus of the counter bank
interface multi_counter_sram_if
  import multi_counter_sram_pkg::*;
#(
  parameter int W = 32,
  parameter int N = 32
) ();
  localparam int AW = $clog2(N);
  logic          cmd_valid;
  logic          cmd_ready;
  op_t           cmd_op;
  logic [AW-1:0] cmd_id;
  logic [W-1:0]  cmd_dat;
  logic          busy_r;
  logic          rsp_valid_r;
  logic [AW-1:0] rsp_id_r;
  logic [W-1:0]  rsp_dat_r;
  logic          evt_ovf_r;
  logic [AW-1:0] evt_id_r;
  modport master (
    output cmd_valid, cmd_op, cmd_id, cmd_dat,
    input  cmd_ready, busy_r, rsp_valid_r, rsp_id_r, rsp_dat_r, evt_ovf_r, evt_id_r
  );
  modport slave (
    input  cmd_valid, cmd_op, cmd_id, cmd_dat,
    output cmd_ready, busy_r, rsp_valid_r, rsp_id_r, rsp_dat_r, evt_ovf_r, evt_id_r
  );
endinterface

// File: rtl/dpsram.sv
// dpsram: dual-port RAM, port 0 registered read, port 1 write
module dpsram #(
  parameter int DW    = 32,
  parameter int DEPTH = 32,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          i_re0,
  input  logic [AW-1:0] i_addr0,
  output logic [DW-1:0] o_rdata0,
  input  logic          i_we1,
  input  logic [AW-1:0] i_addr1,
  input  logic [DW-1:0] i_wdata1
);
  logic [DW-1:0] r_mem [DEPTH];
  // registered read on port 0, write on port 1
  always_ff @(posedge clk) begin
    if (i_re0) o_rdata0 <= r_mem[i_addr0];
    if (i_we1) r_mem[i_addr1] <= i_wdata1;
  end
endmodule

// File: rtl/multi_counter_sram.sv
// multi_counter_sram: SRAM-backed counter bank with zero-sweep and a 4-stage forwarding pipeline
module multi_counter_sram
  import multi_counter_sram_pkg::*;
#(
  parameter int W   = 32,
  parameter int N   = 32,
  parameter bit SAT = 1'b0
) (
  input  logic                clk,
  input  logic                rst,
  multi_counter_sram_if.slave io
);
  localparam int AW = $clog2(N);
  localparam int XW = UC_DAT_W + 1;
  typedef enum logic {SWEEP, RUN} state_t;
  state_t        r_state, w_state_nx;
  logic [AW-1:0] r_ptr, w_ptr_nx;
  logic          w_busy, w_acc;
  ucode_t        w_p0, r_p0, r_p1, r_p2;
  logic [W-1:0]  r_p2_old, w_p1_old, w_rd, w_p2_new;
  logic [XW-1:0] w_sum;
  logic          w_p2_ovf, w_hit2, w_hit3, w_hitl;
  op_t           r_p3_op;
  logic [AW-1:0] r_p3_id;
  logic [W-1:0]  r_p3_old, r_p3_new;
  logic          r_p3_ovf;
  logic          w_we, w_re;
  logic [AW-1:0] w_waddr;
  logic [W-1:0]  w_wdata;
  logic          r_wl_v;
  logic [AW-1:0] r_wl_id;
  logic [W-1:0]  r_wl_dat;
  logic          r_rsp_v, r_evt;
  logic [AW-1:0] r_out_id;
  logic [W-1:0]  r_rsp_dat;

  // sweep/run state and sweep pointer
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r_state <= SWEEP;
      r_ptr   <= '0;
    end else begin
      r_state <= w_state_nx;
      r_ptr   <= w_ptr_nx;
    end

  // sweep one address per cycle, hand over to RUN after the last address
  always_comb begin
    w_state_nx = r_state;
    w_ptr_nx   = r_ptr;
    if (r_state == SWEEP) begin
      w_ptr_nx   = r_ptr + AW'(1);
      w_state_nx = (r_ptr == AW'(N - 1)) ? RUN : SWEEP;
    end
  end

  assign w_busy = r_state == SWEEP;
  assign w_acc  = io.cmd_valid && !w_busy;
  assign w_p0   = '{op: w_acc ? io.cmd_op : OP_NOP, id: UC_ID_W'(io.cmd_id), dat: UC_DAT_W'(io.cmd_dat)};

  assign w_we    = w_busy || op_is_wr(r_p3_op);
  assign w_waddr = w_busy ? r_ptr : r_p3_id;
  assign w_wdata = w_busy ? {W{1'b0}} : r_p3_new;
  assign w_re    = !(w_we && w_waddr == r_p0.id[AW-1:0]);

  dpsram #(.DW(W), .DEPTH(N)) u_ram (
    .clk      (clk),
    .i_re0    (w_re),
    .i_addr0  (r_p0.id[AW-1:0]),
    .o_rdata0 (w_rd),
    .i_we1    (w_we),
    .i_addr1  (w_waddr),
    .i_wdata1 (w_wdata)
  );

  assign w_hit2   = op_is_wr(r_p2.op) && r_p2.id == r_p1.id;
  assign w_hit3   = op_is_wr(r_p3_op) && r_p3_id == r_p1.id[AW-1:0];
  assign w_hitl   = r_wl_v && r_wl_id == r_p1.id[AW-1:0];
  assign w_p1_old = w_hit2 ? w_p2_new : w_hit3 ? r_p3_new : w_hitl ? r_wl_dat : w_rd;

  assign w_sum    = (r_p2.op == OP_SUB) ? XW'(r_p2_old) - XW'(r_p2.dat) : XW'(r_p2_old) + XW'(r_p2.dat);
  assign w_p2_ovf = (r_p2.op == OP_ADD || r_p2.op == OP_SUB) && |w_sum[XW-1:W];
  assign w_p2_new = (r_p2.op == OP_INIT) ? r_p2.dat[W-1:0] :
                    (r_p2.op == OP_QRY_CLR) ? {W{1'b0}} :
                    (w_p2_ovf && SAT) ? {W{r_p2.op == OP_ADD}} : w_sum[W-1:0];

  // pipeline control and strobes; reset drains every stage to NOP
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r_p0     <= '0;
      r_p1     <= '0;
      r_p2     <= '0;
      r_p3_op  <= OP_NOP;
      r_p3_ovf <= 1'b0;
      r_wl_v   <= 1'b0;
      r_rsp_v  <= 1'b0;
      r_evt    <= 1'b0;
    end else begin
      r_p0     <= w_p0;
      r_p1     <= r_p0;
      r_p2     <= r_p1;
      r_p3_op  <= r_p2.op;
      r_p3_ovf <= w_p2_ovf;
      r_wl_v   <= w_we;
      r_rsp_v  <= op_is_out(r_p3_op);
      r_evt    <= r_p3_ovf;
    end

  // pipeline data, last-write copy and response payload
  always_ff @(posedge clk) begin
    r_p2_old  <= w_p1_old;
    r_p3_id   <= r_p2.id[AW-1:0];
    r_p3_old  <= r_p2_old;
    r_p3_new  <= w_p2_new;
    r_wl_id   <= w_waddr;
    r_wl_dat  <= w_wdata;
    r_out_id  <= r_p3_id;
    r_rsp_dat <= r_p3_old;
  end

  assign io.busy_r      = w_busy;
  assign io.cmd_ready   = !w_busy;
  assign io.rsp_valid_r = r_rsp_v;
  assign io.rsp_id_r    = r_out_id;
  assign io.rsp_dat_r   = r_rsp_dat;
  assign io.evt_ovf_r   = r_evt;
  assign io.evt_id_r    = r_out_id;
endmodule
